// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller for a 5-stage core: memory-miss wait, load-use
// stall, branch flush and halt drain, with stall/flush statistics and a memory timeout.
module pipeline_ctrl #(
  parameter int unsigned WAIT_LIMIT   = 255,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        hdu_stall_in,
  input  logic        branch_taken_in,
  input  logic        halt_in,
  input  logic        dmem_req_in,
  input  logic        dmem_ready_in,
  output logic        pc_wr_out,
  output logic        if_id_wr_out,
  output logic        id_ex_wr_out,
  output logic        ex_mem_wr_out,
  output logic        mem_wb_wr_out,
  output logic        if_id_flush_out,
  output logic        id_ex_flush_out,
  output logic        mem_wb_flush_out,
  output logic [1:0]  state_out,
  output logic        halted_out,
  output logic        mem_timeout_out,
  output logic [15:0] stall_cnt_out,
  output logic [15:0] flush_cnt_out
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  localparam logic [15:0] WAIT_LIM16  = 16'(WAIT_LIMIT);
  localparam logic [15:0] DRAIN_LOAD  = 16'(DRAIN_CYCLES);
  localparam logic [15:0] CNT_MAX     = 16'hFFFF;

  // Handshake: a data access is outstanding when dmem_req_in is high; it completes
  // in the cycle dmem_ready_in is high. A miss is a request without ready.

  state_t      r_state;
  logic [15:0] r_drain_cnt;
  logic [15:0] r_wait_cnt;
  logic        r_timeout;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  state_t      w_next_state;
  logic        w_miss;
  logic        w_pc_wr;
  logic        w_if_id_wr;
  logic        w_id_ex_wr;
  logic        w_ex_mem_wr;
  logic        w_mem_wb_wr;
  logic        w_if_id_flush;
  logic        w_id_ex_flush;
  logic        w_mem_wb_flush;
  logic        w_enter_wait;
  logic        w_enter_drain;
  logic [15:0] w_wait_nxt;

  assign w_miss = dmem_req_in & ~dmem_ready_in;

  always_comb begin
    w_next_state   = r_state;
    w_pc_wr        = 1'b1;
    w_if_id_wr     = 1'b1;
    w_id_ex_wr     = 1'b1;
    w_ex_mem_wr    = 1'b1;
    w_mem_wb_wr    = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_mem_wb_flush = 1'b0;
    if (rst_n_in) begin
      case (r_state)
        ST_RUN: begin
          if (w_miss) begin
            w_pc_wr        = 1'b0;
            w_if_id_wr     = 1'b0;
            w_id_ex_wr     = 1'b0;
            w_ex_mem_wr    = 1'b0;
            w_mem_wb_flush = 1'b1;
            w_next_state   = ST_MEM_WAIT;
          end else if (hdu_stall_in) begin
            w_pc_wr       = 1'b0;
            w_if_id_wr    = 1'b0;
            w_id_ex_flush = 1'b1;
          end else if (halt_in) begin
            w_next_state = ST_DRAIN;
          end else if (branch_taken_in) begin
            w_if_id_flush = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          // The completing cycle releases the pipeline with default controls.
          if (!dmem_ready_in) begin
            w_pc_wr        = 1'b0;
            w_if_id_wr     = 1'b0;
            w_id_ex_wr     = 1'b0;
            w_ex_mem_wr    = 1'b0;
            w_mem_wb_flush = 1'b1;
          end else begin
            w_next_state = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (w_miss) begin
            w_pc_wr        = 1'b0;
            w_if_id_wr     = 1'b0;
            w_id_ex_wr     = 1'b0;
            w_ex_mem_wr    = 1'b0;
            w_mem_wb_flush = 1'b1;
          end else begin
            w_pc_wr       = 1'b0;
            w_if_id_flush = 1'b1;
            if (r_drain_cnt <= 16'd1) begin
              w_next_state = ST_HALTED;
            end
          end
        end
        default: begin
          w_pc_wr     = 1'b0;
          w_if_id_wr  = 1'b0;
          w_id_ex_wr  = 1'b0;
          w_ex_mem_wr = 1'b0;
          w_mem_wb_wr = 1'b0;
        end
      endcase
    end
  end

  assign w_enter_wait  = (r_state == ST_RUN) && (w_next_state == ST_MEM_WAIT);
  assign w_enter_drain = (r_state == ST_RUN) && (w_next_state == ST_DRAIN);
  assign w_wait_nxt    = (r_wait_cnt == CNT_MAX) ? r_wait_cnt : r_wait_cnt + 16'd1;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= 16'd0;
      r_wait_cnt  <= 16'd0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      r_state <= w_next_state;

      if (w_enter_drain) begin
        r_drain_cnt <= DRAIN_LOAD;
      end else if ((r_state == ST_DRAIN) && !w_miss && (r_drain_cnt != 16'd0)) begin
        r_drain_cnt <= r_drain_cnt - 16'd1;
      end

      // Timeout stays sticky; the FSM keeps waiting for the memory regardless.
      if (w_enter_wait) begin
        r_wait_cnt <= 16'd0;
      end else if (r_state == ST_MEM_WAIT) begin
        r_wait_cnt <= w_wait_nxt;
        if (w_wait_nxt >= WAIT_LIM16) begin
          r_timeout <= 1'b1;
        end
      end

      if (!w_pc_wr && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_if_id_flush && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign pc_wr_out        = w_pc_wr;
  assign if_id_wr_out     = w_if_id_wr;
  assign id_ex_wr_out     = w_id_ex_wr;
  assign ex_mem_wr_out    = w_ex_mem_wr;
  assign mem_wb_wr_out    = w_mem_wb_wr;
  assign if_id_flush_out  = w_if_id_flush;
  assign id_ex_flush_out  = w_id_ex_flush;
  assign mem_wb_flush_out = w_mem_wb_flush;
  assign state_out        = r_state;
  assign halted_out       = (r_state == ST_HALTED);
  assign mem_timeout_out  = r_timeout;
  assign stall_cnt_out    = r_stall_cnt;
  assign flush_cnt_out    = r_flush_cnt;

endmodule
